// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu_seq multi-cycle sequencer.
// The optional interrupt logic is enabled by defining CPU_SEQ_IRQ_EN.
package cpu_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StIrq    = 3'd5,
        StHalt   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        PcHold   = 3'd0,
        PcInc    = 3'd1,
        PcJump   = 3'd2,
        PcVector = 3'd3,
        PcReturn = 3'd4
    } pc_sel_e;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

    localparam int unsigned DefResetVector = 32'h0000;
    localparam int unsigned DefIrqVector   = 32'h0004;

endpackage

// File: rtl/cpu_seq_if.sv
// Instruction/data memory handshake bundle between the sequencer and the memories.
interface cpu_seq_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] IM_address;
    logic              im_req;
    logic [DATA_W-1:0] IM_data_in;
    logic              im_ready;
    logic              dm_req;
    logic              dm_we;
    logic              dm_ready;

    modport master (
        output IM_address, im_req, dm_req, dm_we,
        input  IM_data_in, im_ready, dm_ready
    );

    modport slave (
        input  IM_address, im_req, dm_req, dm_we,
        output IM_data_in, im_ready, dm_ready
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter, exception return address and next-PC selection.
// EPC exists only when CPU_SEQ_IRQ_EN is defined.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DefResetVector),
    parameter logic [ADDR_W-1:0] IRQ_VECTOR   = ADDR_W'(DefIrqVector)
) (
    input  logic              clk,
    input  logic              reset,
    input  pc_sel_e           pc_sel_i,
    input  logic [ADDR_W-1:0] jmp_target_i,
    input  logic              epc_save_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc;

`ifdef CPU_SEQ_IRQ_EN
    logic [ADDR_W-1:0] epc_q, epc_d;

    assign epc_d = epc_save_i ? pc_q : epc_q;

    always_ff @(posedge clk) begin
        if (reset) epc_q <= '0;
        else       epc_q <= epc_d;
    end

    assign epc = epc_q;
`else
    logic unused_epc_save;
    assign unused_epc_save = epc_save_i;
    assign epc = '0;
`endif

    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel_i)
            PcInc:    pc_d = pc_q + ADDR_W'(1);
            PcJump:   pc_d = jmp_target_i;
            PcVector: pc_d = IRQ_VECTOR;
            PcReturn: pc_d = epc;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_VECTOR;
        else       pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM.
// Define CPU_SEQ_IRQ_EN to add interrupt entry (IRQ state) and rti return.
module cpu_seq
    import cpu_pkg::*;
#(
    parameter int unsigned       DATA_W       = 16,
    parameter int unsigned       ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DefResetVector),
    parameter logic [ADDR_W-1:0] IRQ_VECTOR   = ADDR_W'(DefIrqVector)
) (
    input  logic              clk,
    input  logic              reset,
    cpu_seq_if.master         mem,
    input  logic              halt,
    input  logic              jmp,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic              mem_write,
    input  logic              flags_wr_en,
    input  logic              rti,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic [3:0]        alu_flags,
    input  logic              irq,
    output logic [DATA_W-1:0] IM_data,
    output logic              reg_wr_en,
    output logic [3:0]        flags_out,
    output logic              halt_out,
    output logic [2:0]        state_out
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [3:0]        flags_q, flags_d;
    pc_sel_e           pc_sel;
    logic              epc_save;
    logic              im_req_c, dm_req_c, dm_we_c, reg_wr_en_c, halt_c;
    logic [ADDR_W-1:0] pc;

`ifdef CPU_SEQ_IRQ_EN
    logic [3:0] eflags_q, eflags_d;
    logic       mask_q, mask_d;
`else
    logic unused_irq;
    assign unused_irq = irq ^ rti;
`endif

    pc_unit #(
        .ADDR_W      (ADDR_W),
        .RESET_VECTOR(RESET_VECTOR),
        .IRQ_VECTOR  (IRQ_VECTOR)
    ) u_pc_unit (
        .clk         (clk),
        .reset       (reset),
        .pc_sel_i    (pc_sel),
        .jmp_target_i(jmp_target),
        .epc_save_i  (epc_save),
        .pc_o        (pc)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        flags_d     = flags_q;
        pc_sel      = PcHold;
        epc_save    = 1'b0;
        im_req_c    = 1'b0;
        dm_req_c    = 1'b0;
        dm_we_c     = 1'b0;
        reg_wr_en_c = 1'b0;
        halt_c      = 1'b0;
`ifdef CPU_SEQ_IRQ_EN
        eflags_d    = eflags_q;
        mask_d      = mask_q;
`endif
        unique case (state_q)
            StFetch: begin
                im_req_c = 1'b1;
                if (mem.im_ready) begin
                    ir_d    = mem.IM_data_in;
                    state_d = StDecode;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                if (halt) begin
                    state_d = StHalt;
`ifdef CPU_SEQ_IRQ_EN
                end else if (rti) begin
                    state_d = StFetch;
                    pc_sel  = PcReturn;
                    flags_d = eflags_q;
                    mask_d  = 1'b0;
`endif
                end else if (mem_to_reg || mem_write) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                dm_req_c = 1'b1;
                dm_we_c  = mem_write;
                if (mem.dm_ready) state_d = StWb;
            end
            StWb: begin
                reg_wr_en_c = reg_write;
                if (flags_wr_en) flags_d = alu_flags;
                pc_sel  = jmp ? PcJump : PcInc;
                state_d = StFetch;
`ifdef CPU_SEQ_IRQ_EN
                if (irq && !mask_q) state_d = StIrq;
`endif
            end
            StIrq: begin
`ifdef CPU_SEQ_IRQ_EN
                // PC already points past the interrupted instruction here
                epc_save = 1'b1;
                eflags_d = flags_q;
                mask_d   = 1'b1;
                pc_sel   = PcVector;
`endif
                state_d = StFetch;
            end
            StHalt: halt_c = 1'b1;
            default: state_d = StFetch;
        endcase
        // Reset abandons any in-flight access and silences every strobe
        if (reset) begin
            im_req_c    = 1'b0;
            dm_req_c    = 1'b0;
            dm_we_c     = 1'b0;
            reg_wr_en_c = 1'b0;
            halt_c      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

`ifdef CPU_SEQ_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            eflags_q <= '0;
            mask_q   <= 1'b0;
        end else begin
            eflags_q <= eflags_d;
            mask_q   <= mask_d;
        end
    end
`endif

    assign mem.IM_address = pc;
    assign mem.im_req     = im_req_c;
    assign mem.dm_req     = dm_req_c;
    assign mem.dm_we      = dm_we_c;
    assign IM_data        = ir_q;
    assign reg_wr_en      = reg_wr_en_c;
    assign flags_out      = flags_q;
    assign halt_out       = halt_c;
    assign state_out      = state_q;

endmodule
